ingress_frame_arbiter: RTL and testbench
========================================

Name: ingress_frame_arbiter

Overview:
- Shares the single ingress FIFO write port (8-bit data, write request, full) among NUM_REQ frame sources, e.g. several interface controllers or session engines.
- Grants whole frames atomically: header byte, length byte, payload, ending on last.
- Round-robin between frames, so one source's bytes never interleave with another's.
- Sits directly in front of the ingress FIFO and behind the per-source interface controllers.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- DATA_W, 8, byte width of the FIFO write port.
- TIMEOUT_CYC, 64, stall limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-source byte valid.
- req_data_i  in  NUM_REQ*DATA_W  per-source byte; source k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  per-source final byte of frame.
- req_ready_o  out  NUM_REQ  per-source byte accepted this cycle when valid is also high.
- full_i  in  1  FIFO full.
- data_o  out  DATA_W  byte to FIFO.
- writereq_o  out  1  FIFO write strobe.
- grant_o  out  NUM_REQ  one-hot owner of the current frame; zero when idle.
- frame_done_o  out  1  one-cycle pulse after the last byte is written.
- abort_o  out  NUM_REQ  one-cycle abort pulse to a source (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: state IDLE, grant_o=0, rr_ptr=NUM_REQ-1 (source 0 wins first), frame_done_o=0, abort_o=0. writereq_o and req_ready_o are forced 0 in any cycle rst is high.
- States: IDLE, XFER.
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching upward from rr_ptr+1, modulo NUM_REQ.
  - Register the one-hot grant; state goes to XFER next cycle.
  - One-cycle arbitration bubble; no bytes are accepted in IDLE.
- XFER:
  - req_ready_o[g] = ~full_i; all other ready bits are 0.
  - Transfer occurs when req_valid_i[g] & req_ready_o[g].
  - writereq_o = transfer, combinational, zero latency; data_o = req_data_i slice g.
  - When no transfer, data_o holds its last written value and writereq_o=0.
- Frame end:
  - Transfer with req_last_i[g]=1 sets next state IDLE, rr_ptr <= g, grant_o <= 0, frame_done_o=1 next cycle.
  - Frames from different sources are therefore separated by at least one idle cycle.
- full_i high mid-frame: stall; grant held; no writes; resumes the cycle full_i falls.
- Granted source drops valid mid-frame: grant held indefinitely (unless the optional feature is compiled in).
- Requests from non-granted sources are ignored until frame end; their ready stays 0.
- Single-byte frame (valid and last on the first beat): one write, then back to IDLE.
- Reset mid-frame: grant dropped at the reset edge. The partial frame is not flushed; upstream must also reset.
- Fairness: with all sources continuously requesting, grant order is 0,1,2,3,0,...

Optional Feature:
- Macro: INGRESS_ARB_TIMEOUT_EN.
- With it:
  - A counter increments each XFER cycle where req_valid_i[g]=0 and full_i=0; it clears on any transfer.
  - Reaching TIMEOUT_CYC pulses abort_o[g] for one cycle and returns to IDLE with rr_ptr <= g.
  - frame_done_o does not pulse on an abort.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Without it: no counter, abort_o tied 0, and a stalled owner holds the grant indefinitely.

Decomposition:
- Shared package (ingress_pkg):
  - Typedef of the IDLE/XFER state.
  - Command codes CMD_CONNECT=3'b000, CMD_DISCONNECT=3'b001, CMD_SEND_DATA=3'b010 and the header-field layout, for bench frame construction.
  - LEN_OVERHEAD=21 constant.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, any.
  - Instantiated once.

Test Plan:
- Reset then req0 sends frame 0x02,0x05,0xAA,0xBB(last) → grant_o=0001 one cycle after valid; four consecutive writereq_o; data_o sequence 02,05,AA,BB; frame_done_o pulses the cycle after BB.
- req0..req3 all valid with 3-byte frames → grant order 0,1,2,3,0; no interleaved bytes; one idle cycle between frames.
- full_i high for 5 cycles after byte 2 of a 4-byte frame → no writereq_o during the stall, grant held, remaining bytes written after full_i falls.
- req1 mid-frame while req2 owns the grant → req_ready_o[1]=0 until req2's last byte; req1 granted next.
- rst asserted on byte 3 of a frame → writereq_o=0 that cycle; grant_o=0 next; source 0 wins the next arbitration.
- INGRESS_ARB_TIMEOUT_EN with TIMEOUT_CYC=8: owner drops valid for 8 cycles → abort_o pulses for that source; state returns to IDLE; next source granted.

Source files
------------

// File: rtl/ingress_pkg.sv
// ingress_pkg: shared types and constants for the ingress frame path.
//   arb_state_t   - arbiter FSM state (IDLE / XFER)
//   CMD_*         - frame header command codes
//   HDR_*         - header byte field layout: {cmd[2:0], src[4:0]}
//   LEN_OVERHEAD  - fixed per-frame byte overhead added by upstream framing
//   make_header() - packs a header byte from command and source id
package ingress_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  localparam logic [2:0] CMD_CONNECT    = 3'b000;
  localparam logic [2:0] CMD_DISCONNECT = 3'b001;
  localparam logic [2:0] CMD_SEND_DATA  = 3'b010;

  localparam int HDR_CMD_LSB = 5;
  localparam int HDR_CMD_W   = 3;
  localparam int HDR_SRC_LSB = 0;
  localparam int HDR_SRC_W   = 5;

  localparam int LEN_OVERHEAD = 21;

  function automatic logic [7:0] make_header(input logic [2:0] cmd, input logic [4:0] src);
    return {cmd, src};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  - request vector
//   ptr  - index of the last winner; search starts at ptr+1 (mod NUM_REQ)
//   gnt  - one-hot winner (zero when no request)
//   any  - at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic [PTR_W:0]       shift;
  logic [NUM_REQ-1:0]   rot_lo;
  logic [NUM_REQ-1:0]   first;

  // Rotate so that source ptr+1 sits at bit 0, isolate the lowest set bit,
  // then rotate back. Doubling the vector makes the rotate a plain shift.
  // When NUM_REQ is a power of two, ptr+1 wrapping to zero is still correct.
  always_comb begin
    shift  = {1'b0, ptr} + (PTR_W+1)'(1);
    rot_lo = NUM_REQ'({req, req} >> shift);
    first  = rot_lo & (~rot_lo + NUM_REQ'(1));
    gnt    = NUM_REQ'(({first, first} << shift) >> NUM_REQ);
    any    = |req;
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// ingress_frame_arbiter: shares one ingress FIFO write port among NUM_REQ
// frame sources, granting whole frames round-robin so bytes never interleave.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid_i     per-source byte valid
//   req_data_i      per-source byte, source k at [k*DATA_W +: DATA_W]
//   req_last_i      per-source last byte of frame
//   req_ready_o     per-source accept (only the owner, only when FIFO not full)
//   full_i          FIFO full
//   data_o          byte to FIFO (holds last written byte between writes)
//   writereq_o      FIFO write strobe, combinational
//   grant_o         one-hot frame owner, zero when idle
//   frame_done_o    one-cycle pulse after a frame's last byte is written
//   abort_o         one-cycle abort to a stalled owner
//
// Build option: define INGRESS_ARB_TIMEOUT_EN to abort an owner that offers no
// byte for TIMEOUT_CYC non-full cycles. Without it abort_o is tied 0 and a
// stalled owner keeps the grant indefinitely.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no owner; arbitrate among valid sources (one-cycle bubble)
// ST_XFER | grant_o owns the port until its last byte (or abort)
module ingress_frame_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      full_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      writereq_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      frame_done_o,
  output logic [NUM_REQ-1:0]        abort_o
);
  import ingress_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("ingress_frame_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      g_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  data_sel;
  logic               xfer;
  logic               last_g;
  logic               timeout;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PW)) u_rr_pick (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // grant_o is only non-zero in ST_XFER, so masking by it covers the state.
  assign req_ready_o = rst ? '0 : (grant_o & {NUM_REQ{~full_i}});
  assign xfer        = |(req_valid_i & req_ready_o);
  assign writereq_o  = xfer;
  assign last_g      = |(req_last_i & grant_o);
  assign data_o      = xfer ? data_sel : data_q;

  always_comb begin
    data_sel = '0;
    g_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) begin
        data_sel = req_data_i[k*DATA_W +: DATA_W];
        g_idx    = PW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant_o      <= '0;
      rr_ptr       <= PW'(NUM_REQ - 1);
      frame_done_o <= 1'b0;
      data_q       <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (xfer) data_q <= data_sel;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_o <= pick_gnt;
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer && last_g) begin
            state        <= ST_IDLE;
            grant_o      <= '0;
            rr_ptr       <= g_idx;
            frame_done_o <= 1'b1;
          end else if (timeout) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            rr_ptr  <= g_idx;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INGRESS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] stall_cnt;
  logic          stall;

  // Only owner-side silence counts; FIFO back-pressure neither counts nor clears.
  assign stall   = (state == ST_XFER) && ~|(req_valid_i & grant_o) && ~full_i;
  assign timeout = stall && (stall_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      abort_o   <= '0;
    end else begin
      abort_o <= '0;
      if (state != ST_XFER || xfer || timeout) stall_cnt <= '0;
      else if (stall)                          stall_cnt <= stall_cnt + CW'(1);
      if (timeout) abort_o <= grant_o;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort_o = '0;
`endif

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Self-checking bench for ingress_frame_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a frame-level reference model.
module tb_ingress_frame_arbiter;
  import ingress_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef INGRESS_ARB_TIMEOUT_EN
  localparam int T  = 8;
`else
  localparam int T  = 64;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_last_i;
  logic [N-1:0]    req_ready_o;
  logic            full_i;
  logic [DW-1:0]   data_o;
  logic            writereq_o;
  logic [N-1:0]    grant_o;
  logic            frame_done_o;
  logic [N-1:0]    abort_o;

  ingress_frame_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .full_i       (full_i),
    .data_o       (data_o),
    .writereq_o   (writereq_o),
    .grant_o      (grant_o),
    .frame_done_o (frame_done_o),
    .abort_o      (abort_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-source pending bytes: {last, data}
  logic [8:0] q[N][$];
  bit   mute[N];
  int   gap_pct = 0;
  int   full_pct = 0;
  bit   full_force = 0;
  logic rst_nxt;

  // Reference model
  int         own = -1;
  int         last_own = N - 1;
  bit         exp_done = 0;
  logic [N-1:0] exp_abort = '0;
  int         stall_cnt = 0;
  int         flushed = 0;
  logic [7:0] last_wr = '0;
  bit         have_last = 0;

  // Observation logs
  logic [7:0] wr_log[$];
  int         gnt_log[$];
  logic [N-1:0] prev_g = '0;
  int         abort_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit drained();
    bit d = (own < 0) && !exp_done && (exp_abort == '0);
    for (int s = 0; s < N; s++) if (q[s].size() != 0) d = 0;
    return d;
  endfunction

  task automatic push_frame(input int s, input int len, input logic [7:0] first);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i == 0)      b = first;
      else if (i == 1) b = 8'(len - 2);
      else             b = 8'($urandom_range(255));
      q[s].push_back({(i == len - 1), b});
    end
  endtask

  // One clock: drive after the edge, check at the falling edge, advance the model.
  task automatic cycle();
    logic [N-1:0] v;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] nxt_abort;
    bit exp_wr;
    bit nxt_done;
    @(posedge clk); #1;
    rst = rst_nxt;
    v = '0;
    for (int s = 0; s < N; s++) begin
      if (q[s].size() > 0) begin
        if (!mute[s] && ($urandom_range(99) >= gap_pct)) v[s] = 1'b1;
        req_data_i[s*DW +: DW] = q[s][0][7:0];
        req_last_i[s]          = q[s][0][8];
      end else begin
        req_data_i[s*DW +: DW] = '0;
        req_last_i[s]          = 1'b0;
      end
    end
    req_valid_i = v;
    full_i = full_force || ($urandom_range(99) < full_pct);
    @(negedge clk);

    if (grant_o != '0 && prev_g == '0) gnt_log.push_back(oh2idx(grant_o));
    prev_g = grant_o;
    if (writereq_o) wr_log.push_back(data_o);
    if (abort_o != '0) abort_cnt++;

    exp_g = (own >= 0) ? N'(1 << own) : '0;
    chk("grant", 32'(grant_o), 32'(exp_g));
    chk("frame_done", 32'(frame_done_o), 32'(exp_done));
    chk("abort", 32'(abort_o), 32'(exp_abort));

    if (rst) begin
      chk("rst_writereq", 32'(writereq_o), 0);
      chk("rst_ready", 32'(req_ready_o), 0);
      own = -1; last_own = N - 1; exp_done = 0; exp_abort = '0;
      stall_cnt = 0; have_last = 0;
      for (int s = 0; s < N; s++) q[s].delete();
      return;
    end

    exp_rdy = (own >= 0 && !full_i) ? exp_g : '0;
    exp_wr  = (own >= 0) && v[own] && !full_i;
    chk("ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("writereq", 32'(writereq_o), 32'(exp_wr));

    nxt_done  = 0;
    nxt_abort = '0;
    if (own < 0) begin
      if (v != '0) begin
        for (int d = 1; d <= N; d++) begin
          int idx = (last_own + d) % N;
          if (v[idx]) begin own = idx; break; end
        end
        stall_cnt = 0;
      end
      if (have_last) chk("data_hold", 32'(data_o), 32'(last_wr));
    end else if (exp_wr) begin
      logic [8:0] b = q[own].pop_front();
      chk("data", 32'(data_o), 32'(b[7:0]));
      last_wr = b[7:0]; have_last = 1; stall_cnt = 0;
      if (b[8]) begin nxt_done = 1; last_own = own; own = -1; end
    end else begin
      if (have_last) chk("data_hold", 32'(data_o), 32'(last_wr));
`ifdef INGRESS_ARB_TIMEOUT_EN
      if (!v[own] && !full_i) begin
        stall_cnt++;
        if (stall_cnt == T) begin
          nxt_abort = N'(1 << own);
          while (q[own].size() > 0) begin
            logic [8:0] fb = q[own].pop_front();
            flushed++;
            if (fb[8]) break;
          end
          last_own = own; own = -1; stall_cnt = 0;
        end
      end
`endif
    end
    exp_done  = nxt_done;
    exp_abort = nxt_abort;
  endtask

  task automatic run_drain(input int budget, input string tag);
    int c = 0;
    while (!drained() && c < budget) begin cycle(); c++; end
    chk(tag, 32'(drained()), 1);
  endtask

  task automatic run_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (wr_log.size() < n && c < budget) begin cycle(); c++; end
    chk(tag, 32'(wr_log.size() >= n), 1);
  endtask

  task automatic do_reset();
    rst_nxt = 1'b1;
    cycle();
    rst_nxt = 1'b0;
    cycle();
  endtask

  initial begin
    int total;
    rst = 1'b1; rst_nxt = 1'b1;
    req_valid_i = '0; req_data_i = '0; req_last_i = '0; full_i = 1'b0;
    for (int s = 0; s < N; s++) mute[s] = 0;
    repeat (2) cycle();
    rst_nxt = 1'b0;
    cycle();

    // Basic four-byte frame from source 0
    wr_log.delete(); gnt_log.delete();
    q[0].push_back({1'b0, 8'h02}); q[0].push_back({1'b0, 8'h05});
    q[0].push_back({1'b0, 8'hAA}); q[0].push_back({1'b1, 8'hBB});
    run_drain(50, "t1_drain");
    chk("t1_nwr", wr_log.size(), 4);
    chk("t1_b0", 32'(wr_log[0]), 32'h02);
    chk("t1_b1", 32'(wr_log[1]), 32'h05);
    chk("t1_b2", 32'(wr_log[2]), 32'hAA);
    chk("t1_b3", 32'(wr_log[3]), 32'hBB);
    chk("t1_gnt", 32'(gnt_log[0]), 0);

    // Fairness: every source requesting, source 0 twice
    do_reset();
    wr_log.delete(); gnt_log.delete();
    for (int s = 0; s < N; s++) push_frame(s, 3, make_header(CMD_SEND_DATA, 5'(s)));
    push_frame(0, 3, make_header(CMD_CONNECT, 5'd0));
    run_drain(100, "t2_drain");
    chk("t2_ngnt", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(gnt_log[i]), 32'(i % N));
    chk("t2_nwr", wr_log.size(), 15);

    // FIFO full for five cycles after the second byte
    wr_log.delete(); gnt_log.delete();
    push_frame(1, 4, make_header(CMD_SEND_DATA, 5'd1));
    run_writes(2, 20, "t3_first2");
    full_force = 1;
    repeat (5) cycle();
    chk("t3_stall_nwr", wr_log.size(), 2);
    full_force = 0;
    run_drain(20, "t3_drain");
    chk("t3_nwr", wr_log.size(), 4);

    // Source 1 arrives while source 2 owns the port
    wr_log.delete(); gnt_log.delete();
    push_frame(2, 4, make_header(CMD_SEND_DATA, 5'd2));
    run_writes(1, 20, "t4_first");
    push_frame(1, 2, make_header(CMD_DISCONNECT, 5'd1));
    run_drain(40, "t4_drain");
    chk("t4_ngnt", gnt_log.size(), 2);
    chk("t4_gnt0", 32'(gnt_log[0]), 2);
    chk("t4_gnt1", 32'(gnt_log[1]), 1);

    // Reset on the third byte, then single-byte frames
    wr_log.delete(); gnt_log.delete();
    push_frame(3, 5, make_header(CMD_SEND_DATA, 5'd3));
    run_writes(2, 20, "t5_first2");
    rst_nxt = 1'b1;
    cycle();
    rst_nxt = 1'b0;
    cycle();
    chk("t5_nwr", wr_log.size(), 2);
    gnt_log.delete();
    push_frame(2, 1, make_header(CMD_CONNECT, 5'd2));
    push_frame(0, 1, make_header(CMD_CONNECT, 5'd0));
    run_drain(30, "t5_drain");
    chk("t5_ngnt", gnt_log.size(), 2);
    chk("t5_gnt0", 32'(gnt_log[0]), 0);
    chk("t5_gnt1", 32'(gnt_log[1]), 2);

`ifdef INGRESS_ARB_TIMEOUT_EN
    // Owner goes silent mid-frame
    wr_log.delete(); gnt_log.delete(); abort_cnt = 0;
    push_frame(0, 4, make_header(CMD_SEND_DATA, 5'd0));
    push_frame(1, 2, make_header(CMD_SEND_DATA, 5'd1));
    run_writes(2, 20, "t6_first2");
    mute[0] = 1;
    run_drain(60, "t6_drain");
    mute[0] = 0;
    chk("t6_aborts", abort_cnt, 1);
    chk("t6_gnt0", 32'(gnt_log[0]), 0);
    chk("t6_gnt1", 32'(gnt_log[1]), 1);
`endif

    // Random traffic with valid gaps and back-pressure
    wr_log.delete(); gnt_log.delete(); flushed = 0;
    gap_pct = 15; full_pct = 20;
    total = 0;
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < N; s++) begin
        int len = $urandom_range(1, 6);
        push_frame(s, len, make_header(CMD_SEND_DATA, 5'(s)));
        total += len;
      end
    end
    run_drain(3000, "rand_drain");
    chk("rand_nwr", wr_log.size(), 32'(total - flushed));
    gap_pct = 0; full_pct = 0;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
